// File: rtl/dsp_issue_ctrl.sv
// dsp_issue_ctrl: sequences multi-pass operations onto a DSP datapath with request/result handshakes
module dsp_issue_ctrl #(
  parameter int N = 16,
  parameter int M = 16,
  parameter int ADD_LAT = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_aa,
  input  logic [M-1:0]   in_bb,
  input  logic [N+M-1:0] in_cc,
  input  logic [1:0]     in_mode,
  input  logic           in_mac,
  input  logic [1:0]     in_shift,
  output logic           dsp_start,
  output logic [1:0]     dsp_mode,
  output logic [N-1:0]   dsp_aa,
  output logic [M-1:0]   dsp_bb,
  output logic [N+M-1:0] dsp_cc,
  output logic           dsp_mac,
  output logic [1:0]     dsp_barrel_shifter,
  input  logic [N+M-1:0] dsp_out,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N+M-1:0] out_data,
  output logic [1:0]     out_mode,
  output logic           busy
);
  typedef enum logic [1:0] {IDLE, RUN, WAIT_ADD} state_t;
  localparam logic [1:0] LAT_LAST = 2'(ADD_LAT > 0 ? ADD_LAT - 1 : 0);
  state_t state_q, state_d;
  logic [1:0] pass_q, pass_d, lat_q, lat_d, mode_q, mode_d, shift_q, shift_d, omode_q, omode_d;
  logic [N-1:0] aa_q, aa_d;
  logic [M-1:0] bb_q, bb_d;
  logic [N+M-1:0] cc_q, cc_d, odata_q, odata_d;
  logic start_q, start_d, mac_q, mac_d, ovalid_q, ovalid_d;
  logic accept, last_pass, capture;
  assign in_ready = (state_q == IDLE) && (!ovalid_q || out_ready);
  assign dsp_start = start_q;
  assign dsp_mode = mode_q;
  assign dsp_aa = aa_q;
  assign dsp_bb = bb_q;
  assign dsp_cc = cc_q;
  assign dsp_mac = mac_q;
  assign dsp_barrel_shifter = shift_q;
  assign out_valid = ovalid_q;
  assign out_data = odata_q;
  assign out_mode = omode_q;
  assign busy = state_q != IDLE;
  // next-state: accept loads operands, RUN walks the passes, WAIT_ADD drains the adder pipe, capture latches the result
  always_comb begin
    accept = in_valid && in_ready;
    last_pass = pass_q == (mode_q == 2'd0 ? 2'd0 : mode_q == 2'd1 ? 2'd1 : 2'd3);
    capture = (state_q == RUN && last_pass && ADD_LAT == 0) || (state_q == WAIT_ADD && lat_q == LAT_LAST);
    state_d = accept ? RUN : capture ? IDLE : (state_q == RUN && last_pass) ? WAIT_ADD : state_q;
    pass_d = accept ? 2'd0 : state_q == RUN ? pass_q + 2'd1 : pass_q;
    lat_d = state_q == WAIT_ADD ? lat_q + 2'd1 : 2'd0;
    start_d = accept;
    aa_d = accept ? in_aa : aa_q;
    bb_d = accept ? in_bb : bb_q;
    cc_d = accept ? in_cc : cc_q;
    mode_d = accept ? in_mode : mode_q;
    mac_d = accept ? in_mac : mac_q;
    shift_d = accept ? in_shift : shift_q;
    omode_d = accept ? in_mode : omode_q;
    ovalid_d = capture || (ovalid_q && !out_ready);
    odata_d = capture ? dsp_out : odata_q;
  end
  // state and registered outputs; reset clears everything, dropping any in-flight result
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pass_q <= '0;
      lat_q <= '0;
      start_q <= 1'b0;
      aa_q <= '0;
      bb_q <= '0;
      cc_q <= '0;
      mode_q <= '0;
      mac_q <= 1'b0;
      shift_q <= '0;
      omode_q <= '0;
      ovalid_q <= 1'b0;
      odata_q <= '0;
    end else begin
      state_q <= state_d;
      pass_q <= pass_d;
      lat_q <= lat_d;
      start_q <= start_d;
      aa_q <= aa_d;
      bb_q <= bb_d;
      cc_q <= cc_d;
      mode_q <= mode_d;
      mac_q <= mac_d;
      shift_q <= shift_d;
      omode_q <= omode_d;
      ovalid_q <= ovalid_d;
      odata_q <= odata_d;
    end
  end
endmodule

// File: tb/tb_dsp_issue_ctrl.sv
// tb_dsp_issue_ctrl: random and directed checks of dsp_issue_ctrl for ADD_LAT 0 and 2 against a timing model
module tb_dsp_issue_ctrl;
  localparam int N = 16, M = 16, W = N + M, NCYC = 3000;
  logic clk = 1'b0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  task automatic chk(input int inst, input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL i%0d %s got=%0h exp=%0h", inst, tag, got, exp);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = 2 * g;
    logic reset, in_valid, in_ready, in_mac, dsp_start, dsp_mac, out_valid, out_ready, busy;
    logic [N-1:0] in_aa, dsp_aa;
    logic [M-1:0] in_bb, dsp_bb;
    logic [W-1:0] in_cc, dsp_cc, dsp_out, out_data;
    logic [1:0] in_mode, in_shift, dsp_mode, dsp_barrel_shifter, out_mode;
    dsp_issue_ctrl #(.N(N), .M(M), .ADD_LAT(LAT)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_aa(in_aa), .in_bb(in_bb), .in_cc(in_cc), .in_mode(in_mode), .in_mac(in_mac), .in_shift(in_shift),
      .dsp_start(dsp_start), .dsp_mode(dsp_mode), .dsp_aa(dsp_aa), .dsp_bb(dsp_bb), .dsp_cc(dsp_cc),
      .dsp_mac(dsp_mac), .dsp_barrel_shifter(dsp_barrel_shifter), .dsp_out(dsp_out),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode), .busy(busy)
    );
    initial begin : stim
      int cyc, acc, p, nacc, acc_k, res_k;
      bit ov, inflight, cap, e_ready;
      logic [N-1:0] m_aa;
      logic [M-1:0] m_bb;
      logic [W-1:0] m_cc, od;
      logic [W-1:0] gold [3];
      logic [1:0] m_mode, m_shift, om;
      logic m_mac;
      gold[0] = 32'h0000003F; gold[1] = 32'h06260060; gold[2] = 32'h06260060;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_aa = '0; in_bb = '0; in_cc = '0;
      in_mode = '0; in_mac = 1'b0; in_shift = '0; dsp_out = '0;
      cyc = 0; acc = -100; p = 1; nacc = 0; acc_k = 0; res_k = -1; ov = 0; od = '0; om = '0;
      m_aa = '0; m_bb = '0; m_cc = '0; m_mode = '0; m_shift = '0; m_mac = 1'b0;
      for (int c = 0; c < NCYC; c++) begin
        @(negedge clk);
        reset = (c < 2) || (c > 60 && $urandom_range(99) < 2);
        in_valid = $urandom_range(9) < 7;
        out_ready = $urandom_range(9) < 6;
        in_aa = N'($urandom); in_bb = M'($urandom); in_cc = W'($urandom);
        in_mode = 2'($urandom); in_mac = 1'($urandom); in_shift = 2'($urandom);
        if (nacc < 3 && !reset) begin
          in_valid = 1'b1; out_ready = 1'b1; in_cc = '0; in_mac = 1'b0;
          in_mode = nacc == 0 ? 2'd0 : nacc == 1 ? 2'd2 : 2'd3;
          in_aa = nacc == 0 ? 16'h0007 : 16'h1234;
          in_bb = nacc == 0 ? 16'h0009 : 16'h5678;
        end
        inflight = acc >= 0 && cyc >= acc + 1 && cyc <= acc + p + LAT;
        cap = inflight && cyc == acc + p + LAT;
        dsp_out = cap ? W'(m_aa) * W'(m_bb) + m_cc : W'($urandom);
        #1;
        e_ready = !inflight && (!ov || out_ready);
        chk(g, "in_ready", in_ready, e_ready);
        chk(g, "busy", busy, inflight);
        chk(g, "dsp_start", dsp_start, inflight && cyc == acc + 1);
        chk(g, "dsp_aa", dsp_aa, m_aa);
        chk(g, "dsp_bb", dsp_bb, m_bb);
        chk(g, "dsp_cc", dsp_cc, m_cc);
        chk(g, "dsp_mode", dsp_mode, m_mode);
        chk(g, "dsp_mac", dsp_mac, m_mac);
        chk(g, "dsp_shift", dsp_barrel_shifter, m_shift);
        chk(g, "out_valid", out_valid, ov);
        chk(g, "out_data", out_data, od);
        chk(g, "out_mode", out_mode, om);
        if (ov && res_k >= 0 && res_k < 3) chk(g, "golden", out_data, gold[res_k]);
        if (reset) begin
          acc = -100; ov = 0; od = '0; om = '0; res_k = -1;
          m_aa = '0; m_bb = '0; m_cc = '0; m_mode = '0; m_shift = '0; m_mac = 1'b0;
        end else begin
          if (cap) begin ov = 1; od = dsp_out; res_k = acc_k; end
          else if (ov && out_ready) ov = 0;
          if (e_ready && in_valid) begin
            acc = cyc; acc_k = nacc; nacc++;
            m_aa = in_aa; m_bb = in_bb; m_cc = in_cc; m_mode = in_mode; m_mac = in_mac; m_shift = in_shift;
            om = in_mode;
            p = in_mode == 2'd0 ? 1 : in_mode == 2'd1 ? 2 : 4;
          end
        end
        cyc++;
      end
    end
  end
  initial begin
    repeat (NCYC + 20) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
